// File: rtl/player_motion_ctrl_if.sv
// Signal bundle between the keyboard/collision sources and the player motion controller.
// The controller uses the slave modport; the key/collision source side uses master.
interface player_motion_ctrl_if;
    logic       startOfFrame;
    logic       leftKey;
    logic       rightKey;
    logic       collision;
    logic [3:0] HitEdgeCode;
    logic       moveLeftN;
    logic       moveRightN;
    logic [6:0] speed;
    logic       blocked;

    modport master (
        output startOfFrame, leftKey, rightKey, collision, HitEdgeCode,
        input  moveLeftN, moveRightN, speed, blocked
    );

    modport slave (
        input  startOfFrame, leftKey, rightKey, collision, HitEdgeCode,
        output moveLeftN, moveRightN, speed, blocked
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Frame-rate horizontal motion sequencer: key arbitration, speed ramp and
// collision blocking, with registered active-low move enables for the mover.
module player_motion_ctrl #(
    parameter int MIN_SPEED = 16,
    parameter int MAX_SPEED = 64,
    parameter int ACCEL     = 4
) (
    input  logic                 clk,
    input  logic                 resetN,
    player_motion_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, RUN_L, RUN_R, BLOCK_L, BLOCK_R} state_t;

    localparam logic [6:0] MIN_SPD = 7'(MIN_SPEED);
    localparam logic [7:0] MAX_SPD = 8'(MAX_SPEED);
    localparam logic [7:0] ACC     = 8'(ACCEL);

    state_t     state_q, state_d;
    logic [6:0] speed_q, speed_d, speed_o_d;
    logic       hit_l_q, hit_r_q;
    logic       hit_l, hit_r;
    logic       key_l, key_r, key_b, key_n;
    logic [7:0] ramp;
    logic       move_l_n_q, move_r_n_q, blocked_q;
    logic       move_l_n_d, move_r_n_d, blocked_d;

    // A collision arriving in the startOfFrame cycle belongs to this frame.
    assign hit_l = hit_l_q | (bus.collision & bus.HitEdgeCode[3]);
    assign hit_r = hit_r_q | (bus.collision & bus.HitEdgeCode[1]);

    assign key_l = bus.leftKey & ~bus.rightKey;
    assign key_r = bus.rightKey & ~bus.leftKey;
    assign key_b = bus.leftKey & bus.rightKey;
    assign key_n = ~bus.leftKey & ~bus.rightKey;

    assign ramp = {1'b0, speed_q} + ACC;

    // Collision latches; each frame consumes whatever has gathered, state or not.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_l_q <= 1'b0;
            hit_r_q <= 1'b0;
        end else if (bus.startOfFrame) begin
            hit_l_q <= 1'b0;
            hit_r_q <= 1'b0;
        end else if (bus.collision) begin
            // NOTE: non-blocking assignments in clocked blocks so every register
            // samples pre-edge values regardless of block ordering.
            if (bus.HitEdgeCode[3]) hit_l_q <= 1'b1;
            if (bus.HitEdgeCode[1]) hit_r_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            speed_q    <= '0;
            move_l_n_q <= 1'b1;
            move_r_n_q <= 1'b1;
            blocked_q  <= 1'b0;
        end else if (bus.startOfFrame) begin
            state_q    <= state_d;
            speed_q    <= speed_o_d;
            move_l_n_q <= move_l_n_d;
            move_r_n_q <= move_r_n_d;
            blocked_q  <= blocked_d;
        end
    end

    always_comb begin
        // NOTE: defaults up front keep every path assigned, so no latches are inferred.
        state_d = state_q;
        speed_d = speed_q;
        unique case (state_q)
            IDLE: begin
                if (key_l) begin
                    state_d = RUN_L;
                    speed_d = MIN_SPD;
                end else if (key_r) begin
                    state_d = RUN_R;
                    speed_d = MIN_SPD;
                end
            end
            RUN_L: begin
                if (hit_r) begin
                    state_d = BLOCK_L;
                    speed_d = '0;
                end else if (key_l || key_b) begin
                    speed_d = (ramp > MAX_SPD) ? MAX_SPD[6:0] : ramp[6:0];
                end else if (key_r) begin
                    state_d = RUN_R;
                    speed_d = MIN_SPD;
                end else begin
                    state_d = IDLE;
                    speed_d = '0;
                end
            end
            RUN_R: begin
                if (hit_l) begin
                    state_d = BLOCK_R;
                    speed_d = '0;
                end else if (key_r || key_b) begin
                    speed_d = (ramp > MAX_SPD) ? MAX_SPD[6:0] : ramp[6:0];
                end else if (key_l) begin
                    state_d = RUN_L;
                    speed_d = MIN_SPD;
                end else begin
                    state_d = IDLE;
                    speed_d = '0;
                end
            end
            // Blocked direction needs a release before it may run again.
            BLOCK_L: begin
                if (key_r) begin
                    state_d = RUN_R;
                    speed_d = MIN_SPD;
                end else if (key_n) begin
                    state_d = IDLE;
                end
            end
            BLOCK_R: begin
                if (key_l) begin
                    state_d = RUN_L;
                    speed_d = MIN_SPD;
                end else if (key_n) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                speed_d = '0;
            end
        endcase
    end

    always_comb begin
        move_l_n_d = (state_d != RUN_L);
        move_r_n_d = (state_d != RUN_R);
        blocked_d  = (state_d == BLOCK_L) || (state_d == BLOCK_R);
        speed_o_d  = ((state_d == RUN_L) || (state_d == RUN_R)) ? speed_d : 7'd0;
    end

    assign bus.moveLeftN  = move_l_n_q;
    assign bus.moveRightN = move_r_n_q;
    assign bus.speed      = speed_q;
    assign bus.blocked    = blocked_q;

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
Frame-rate controller that sequences the horizontal player mover from raw left/right key levels and object-collision reports. Arbitrates simultaneous key presses and ramps speed while a key is held. Blocks motion into an object that was hit, and drives the mover's active-low move enables plus its speed value. Sits between the keyboard decoder, the collision detector and the player position/move block.

Parameters:
MIN_SPEED, 16, speed loaded on entering a run state (1/64 pixel per frame units)
MAX_SPEED, 64, saturation ceiling of speed; must be <= 127
ACCEL, 4, speed increment per frame while the same direction is held

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  single-cycle pulse at the start of each frame
leftKey  in  1  high while the left key is held
rightKey  in  1  high while the right key is held
collision  in  1  single-cycle pulse, player overlaps an object
HitEdgeCode  in  4  {Left,Top,Right,Bottom} edge of object hit; valid with collision
moveLeftN  out  1  low = mover steps left this frame
moveRightN  out  1  low = mover steps right this frame
speed  out  7  unsigned step size for the mover
blocked  out  1  high while in a BLOCK state

Behaviour:
- Reset (async, resetN low): state IDLE, moveLeftN=1, moveRightN=1, speed=0, blocked=0, collision latches cleared. Deassertion has effect at the next clk edge.
- Collision latches hitL and hitR:
  - Set on any cycle where collision=1: hitR if HitEdgeCode[1]=1 (object's right edge, blocks leftward motion); hitL if HitEdgeCode[3]=1 (blocks rightward motion).
  - Both may set together.
  - Cleared in the cycle after startOfFrame consumes them. A collision in the same cycle as startOfFrame is consumed in that frame.
- State updates only on startOfFrame. Outputs are registered and change one clk after startOfFrame.
- States: IDLE, RUN_L, RUN_R, BLOCK_L, BLOCK_R.
- Key decode at frame: L = leftKey & ~rightKey; R = rightKey & ~leftKey; B = both keys; N = neither.
- IDLE:
  - L -> RUN_L, speed=MIN_SPEED.
  - R -> RUN_R, speed=MIN_SPEED.
  - B or N -> stay IDLE.
- RUN_L:
  - hitR -> BLOCK_L, speed=0. Collision takes priority over keys.
  - else L or B -> stay RUN_L, speed=min(speed+ACCEL, MAX_SPEED). Computed in 8 bits, no wrap.
  - else R -> RUN_R, speed=MIN_SPEED.
  - else N -> IDLE, speed=0.
- RUN_R: mirror of RUN_L, using hitL and BLOCK_R.
- BLOCK_L:
  - R -> RUN_R, speed=MIN_SPEED.
  - N -> IDLE.
  - L or B -> stay BLOCK_L. Release is required before moving left again.
- BLOCK_R: mirror of BLOCK_L.
- Output decode (registered from next state):
  - moveLeftN=0 only in RUN_L; moveRightN=0 only in RUN_R. Never both low.
  - blocked=1 in BLOCK_L or BLOCK_R.
  - speed=0 whenever not in a RUN state.
- Collisions outside RUN states are latched and then discarded at the frame.
- Key changes between frames are ignored; only the level at startOfFrame matters.
- Reset mid-run returns to IDLE immediately, asynchronously, with all outputs at reset values.

Test Plan:
- Reset, then leftKey=1 for 5 frames -> moveLeftN=0 from frame 1; speed 16,20,24,28,32; moveRightN=1 throughout.
- leftKey held 20 frames -> speed saturates at 64 from frame 13 and never exceeds 64; release -> IDLE, speed=0, both enables high.
- In RUN_R at speed 40, press leftKey with rightKey still held -> stays RUN_R, speed 44. Release rightKey -> RUN_L, speed=16.
- In RUN_L, pulse collision with HitEdgeCode=4'b0010 mid-frame -> next frame BLOCK_L, blocked=1, moveLeftN=1, speed=0. Left held 3 more frames -> stays blocked. Press right only -> RUN_R, speed=16.
- In RUN_R, collision with HitEdgeCode=4'b0010 (wrong edge) -> remains RUN_R, speed keeps ramping. Collision in IDLE -> ignored and latch cleared.
- Assert resetN=0 asynchronously mid-frame in RUN_L at speed 48 -> moveLeftN=1 and speed=0 without waiting for a clk edge. After release, IDLE until the next startOfFrame with a key held.
